ysyx_25040109_mdu_seq: RTL and testbench

//  Multi-cycle sequencer for the RV32M datapath: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/ysyx_25040109_mdu_pkg.sv | 23 ++
 rtl/ysyx_25040109_mdu_div_step.sv | 21 ++
 rtl/ysyx_25040109_mdu_seq.sv | 183 ++++++++++++++++++
 tb/tb_ysyx_25040109_mdu_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040109_mdu_pkg.sv
// Shared types and RV32M funct3 encodings for the multi-cycle mul/div sequencer.
package ysyx_25040109_mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/ysyx_25040109_mdu_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module ysyx_25040109_mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Extra top bit: the shifted partial remainder can reach 2*divisor-1.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_i};
  assign rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/ysyx_25040109_mdu_seq.sv
// Iterative RV32M mul/div sequencer with valid/ready on both sides.
// Define YSYX_25040109_MDU_FAST_MUL_EN for single-edge combinational multiplies.
module ysyx_25040109_mdu_seq
  import ysyx_25040109_mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int ITERS = XLEN / STEPS;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] mag_b_q, hi_q, lo_q, result_q;
  logic [4:0]      rd_q;

  logic            accept, a_signed, b_signed, neg_a, neg_b, neg_res;
  logic            b_zero, ovf, special, fast_op;
  logic [XLEN-1:0] mag_a, mag_b, special_val;

  // Divide: hi=remainder, lo=quotient. Multiply: {hi,lo}=product.
  function automatic logic [XLEN-1:0] fix_result(input logic [2:0] f, input logic neg,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   val;
    if (is_div(f)) begin
      val        = f[1] ? hi : lo;
      fix_result = neg ? -val : val;
    end else begin
      prod       = neg ? -{hi, lo} : {hi, lo};
      fix_result = (f == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  endfunction

  assign accept   = in_valid & in_ready;
  assign a_signed = (in_funct3 == F3_MUL) | (in_funct3 == F3_MULH) | (in_funct3 == F3_MULHSU) |
                    (in_funct3 == F3_DIV) | (in_funct3 == F3_REM);
  assign b_signed = (in_funct3 == F3_MUL) | (in_funct3 == F3_MULH) |
                    (in_funct3 == F3_DIV) | (in_funct3 == F3_REM);
  assign neg_a    = a_signed & in_a[XLEN-1];
  assign neg_b    = b_signed & in_b[XLEN-1];
  assign mag_a    = neg_a ? -in_a : in_a;
  assign mag_b    = neg_b ? -in_b : in_b;
  // Remainder takes the dividend's sign; quotient and product take the xor.
  assign neg_res  = (is_div(in_funct3) && in_funct3[1]) ? neg_a : (neg_a ^ neg_b);

  assign b_zero      = (in_b == '0);
  assign ovf         = (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == '1) &
                       ((in_funct3 == F3_DIV) | (in_funct3 == F3_REM));
  assign special     = is_div(in_funct3) & (b_zero | ovf);
  assign special_val = b_zero ? (in_funct3[1] ? in_a : '1) : (in_funct3[1] ? '0 : in_a);

`ifdef YSYX_25040109_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_op   = ~is_div(in_funct3);
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
  assign fast_op = 1'b0;
`endif

  logic [XLEN-1:0] hi_c [STEPS+1];
  logic [XLEN-1:0] lo_c [STEPS+1];

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    logic [XLEN-1:0] div_rem, div_quo;

    ysyx_25040109_mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_i     (hi_c[gi]),
      .quo_i     (lo_c[gi]),
      .divisor_i (mag_b_q),
      .rem_o     (div_rem),
      .quo_o     (div_quo)
    );

`ifdef YSYX_25040109_MDU_FAST_MUL_EN
    assign hi_c[gi+1] = div_rem;
    assign lo_c[gi+1] = div_quo;
`else
    // Shift-add: lo holds the unconsumed multiplier bits and fills with product bits.
    logic [XLEN:0] sum;
    assign sum        = {1'b0, hi_c[gi]} + (lo_c[gi][0] ? {1'b0, mag_b_q} : '0);
    assign hi_c[gi+1] = is_div(op_q) ? div_rem : sum[XLEN:1];
    assign lo_c[gi+1] = is_div(op_q) ? div_quo : {sum[0], lo_c[gi][XLEN-1:1]};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (special | fast_op) ? DONE : CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = ~flush;
        busy     = 1'b0;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      rd_q     <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      op_q    <= in_funct3;
      rd_q    <= in_rd;
      neg_q   <= neg_res;
      mag_b_q <= mag_b;
      hi_q    <= '0;
      lo_q    <= mag_a;
      cnt_q   <= '0;
      if (special) begin
        result_q <= special_val;
`ifdef YSYX_25040109_MDU_FAST_MUL_EN
      end else if (fast_op) begin
        result_q <= fix_result(in_funct3, neg_res, fast_prod[2*XLEN-1:XLEN], fast_prod[XLEN-1:0]);
`endif
      end
    end else if (state_q == CALC) begin
      hi_q  <= hi_c[STEPS];
      lo_q  <= lo_c[STEPS];
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        result_q <= fix_result(op_q, neg_q, hi_c[STEPS], lo_c[STEPS]);
      end
    end
  end

  assign out_result = result_q;
  assign out_rd     = rd_q;

endmodule

// File: tb/tb_ysyx_25040109_mdu_seq.sv
// Self-checking bench for ysyx_25040109_mdu_seq: directed table, random ops, corner sequences.
module tb_ysyx_25040109_mdu_seq;
  import ysyx_25040109_mdu_pkg::*;

`ifdef YSYX_25040109_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  in_funct3;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_rd, out_rd;

  int checks = 0;
  int errors = 0;

  ysyx_25040109_mdu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural RV32M result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, prod;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_result = '0;
    case (f)
      F3_MUL:    begin prod = sa * sb; ref_result = prod[31:0]; end
      F3_MULH:   begin prod = sa * sb; ref_result = prod[63:32]; end
      F3_MULHSU: begin prod = sa * longint'(ub); ref_result = prod[63:32]; end
      F3_MULHU:  begin pu = ua * ub; ref_result = pu[63:32]; end
      F3_DIV:    begin prod = (b == 0) ? -64'sd1 : sa / sb; ref_result = prod[31:0]; end
      F3_DIVU:   ref_result = (b == 0) ? 32'hFFFFFFFF : 32'(ua / ub);
      F3_REM:    begin prod = (b == 0) ? sa : sa % sb; ref_result = prod[31:0]; end
      F3_REMU:   ref_result = (b == 0) ? a : 32'(ua % ub);
      default:   ref_result = '0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return DIV_LAT;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_funct3 = f;
    in_a      = a;
    in_b      = b;
    in_rd     = rd;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_funct3 = 3'($urandom);
    in_a      = $urandom;
    in_b      = $urandom;
    in_rd     = 5'($urandom);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, lat);
    check("result", out_result, exp);
    check("rd", out_rd, rd);
    $display("op f=%0d a=%h b=%h rd=%0d -> result=%h (exp %h) edges=%0d", f, a, b, rd,
             out_result, exp, n);
    @(negedge clk);
    check("handshake_drop", out_valid, 0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[3]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[4]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[5]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14};
    vecs[6]  = '{F3_REMU,   32'd100,      32'd7,        32'd2};
    vecs[7]  = '{F3_DIV,    32'd1234,     32'd0,        32'hFFFFFFFF};
    vecs[8]  = '{F3_REMU,   32'd5,        32'd0,        32'd5};
    vecs[9]  = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[10] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0};
    vecs[11] = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    vecs[12] = '{F3_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
    vecs[13] = '{F3_MUL,    32'h00012345, 32'h00010000, 32'h23450000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_a = '0; in_b = '0; in_rd = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {out_valid, busy, out_result, out_rd}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp,
             ref_lat(vecs[i].f, vecs[i].a, vecs[i].b));
    end

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb, 5'($urandom), ref_result(rf, ra, rb), ref_lat(rf, ra, rb));
    end

    // Backpressure: result must hold and no new op may sneak in while DONE.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_funct3 = F3_DIVU; in_a = 32'd100; in_b = 32'd7;
    in_rd = 5'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    @(negedge clk);
    while (!out_valid && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    check("bp_valid_rise", out_valid, 1);
    in_valid = 1'b1; in_funct3 = F3_MUL; in_a = 32'd3; in_b = 32'd3; in_rd = 5'd4;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {out_valid, in_ready, out_rd, out_result}, {1'b1, 1'b0, 5'd9, 32'd14});
      $display("bp cycle %0d valid=%0d result=%h rd=%0d", i, out_valid, out_result, out_rd);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_one_handshake", {out_valid, busy}, 0);
    @(negedge clk);
    check("bp_no_second", {out_valid, busy}, 0);

    // Flush mid-CALC with a competing request in the same cycle.
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = F3_DIV; in_a = 32'hFFFFFFF9; in_b = 32'd2; in_rd = 5'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_funct3 = F3_DIVU; in_a = 32'd100; in_b = 32'd7;
    in_rd = 5'd7;
    check("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", {busy, out_valid}, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("flush_no_result", seen, 0);
    $display("flush sequence done");
    run_op(F3_REM, 32'hFFFFFFF9, 32'd2, 5'd12, 32'hFFFFFFFF, DIV_LAT);

    // Asynchronous reset mid-CALC aborts to reset values at once.
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = F3_DIVU; in_a = 32'd1000; in_b = 32'd3; in_rd = 5'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {busy, out_valid, out_result, out_rd}, 0);
    $display("async reset applied mid-op");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(F3_DIVU, 32'd1000, 32'd3, 5'd6, 32'd333, DIV_LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
